mem_resp_pipelined: RTL and testbench
=====================================

# mem_resp_pipelined

Pipelined, fixed-latency main-memory responder: the memory-side end of the `enable`/`wr`/`addr`/`data_in`/`data_out` request interface that the pipelined `cpu` drives. It accepts one read or write request per cycle, commits writes immediately, and returns read data exactly `LATENCY` cycles later with a `data_valid` strobe. It replaces the single-cycle instruction and data memories below the upcoming cache fill/writeback path, and in tests it stands in for DRAM timing.

## Interface
- `DWIDTH`, 16, data word width in bits.
- `AWIDTH`, 16, byte-address width. The array holds 2^(AWIDTH-1) words.
- `LATENCY`, 4, number of cycles from read acceptance to `data_valid`. Legal range 1–8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `enable`  in  1  request valid this cycle.
- `wr`  in  1  with `enable`: 1 = write, 0 = read.
- `addr`  in  AWIDTH  byte address; bit 0 is ignored (word index = `addr[AWIDTH-1:1]`).
- `data_in`  in  DWIDTH  write data.
- `data_out`  out  DWIDTH  read data; meaningful only while `data_valid` = 1.
- `data_valid`  out  1  one-cycle strobe per completed read.
- `outstanding`  out  4  count of reads accepted but not yet returned.

## Operation
- A request is accepted on every rising edge where `enable` = 1. There is no backpressure; the block is always ready.
- **Write** (`enable`=1, `wr`=1): `mem[addr[AWIDTH-1:1]]` ← `data_in` at that edge. It produces no `data_valid`.
- **Read** (`enable`=1, `wr`=0): the word is sampled from the array at the accepting edge. The sampled data and a valid bit then travel through a `LATENCY`-deep delay line.
- Read/write ordering is strictly program-ordered:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
  - A read at edge N followed by a write at edge N+1 returns the old data.
- Responses return in request order. Back-to-back reads produce back-to-back `data_valid` pulses.
- `outstanding` behaviour:
  - It is incremented on read acceptance and decremented on each `data_valid` edge.
  - When both happen on the same edge, it is unchanged.
  - Its maximum is `LATENCY`, so it can never wrap.
- `data_out` is 0 whenever `data_valid` = 0; it is never a stale value.
- `enable` = 0 is a no-op. `wr` and `addr` are ignored when `enable` = 0.

## Timing
- **Reset values:** `data_valid` = 0, `data_out` = 0, `outstanding` = 0. Every delay-line valid bit is cleared.
- **Reset does not clear the array**; its contents persist across reset.
- **Reset mid-operation:** in-flight reads are discarded and never return. After `rst` deasserts, the first accepting edge behaves as after power-up.
- **Read latency:** read accepted at edge N → `data_valid` = 1 and `data_out` valid during the cycle following edge N+LATENCY-1. That is, exactly `LATENCY` cycles after the request cycle. With `LATENCY` = 1 this is a registered read.
- **Write latency:** the write is visible to a read accepted on the next edge.
- **Throughput:** one request per cycle, sustained indefinitely.

## Configuration
- **`MEMRESP_WR_ACK_EN` defined:**
  - Adds output `wr_ack` (1 bit, reset 0).
  - Each accepted write injects a marker into the same delay line. `wr_ack` pulses exactly `LATENCY` cycles after the write, in order with read responses.
  - `data_valid` stays low for write slots.
  - `outstanding` also counts pending writes.
- **`MEMRESP_WR_ACK_EN` undefined:**
  - No `wr_ack` port.
  - Writes consume no delay-line slot and `outstanding` counts reads only.

## Structure
- **Shared package `wisc_mem_pkg`** holds:
  - the `DWIDTH`/`AWIDTH`/`LATENCY` defaults;
  - typedef `mem_resp_t` = {valid, is_wr_ack, data[DWIDTH-1:0]}, one delay-line entry;
  - the `MAX_LATENCY` = 8 constant used to size `outstanding`.
- **Sub-module `mem_resp_delay`:** parameterized `LATENCY`-stage shift register of `mem_resp_t` with asynchronous active-low clear of the valid bits. The top level contains the array, the accept logic and the `outstanding` counter.
- **Array:** behavioural reg array with no reset. It supports `$readmemh` preload under simulation only.

## Test plan
- **Reset values:** hold `rst`=0 for 3 cycles → `data_valid`=0, `data_out`=0, `outstanding`=0. Then write 0x1234 to 0x0010 and read 0x0010 → `data_valid` exactly 4 cycles later with `data_out`=0x1234.
- **Streaming reads:** after writing 0xA000+i to address 2i for i=0..7, issue 8 back-to-back reads →
  - `data_valid` is high for 8 consecutive cycles starting 4 cycles after the first read;
  - data arrives in order 0xA000..0xA007;
  - `outstanding` peaks at 4.
- **Write/read ordering:** read 0x0040 (old value 0x5555), then next cycle write 0xBEEF to 0x0040, then read 0x0040 → first response 0x5555, second response 0xBEEF.
- **Reset mid-operation and odd addresses:**
  - 2 reads in flight then pulse `rst` low → no `data_valid` appears, `outstanding`=0, and a previously written word is still readable after reset.
  - Reading odd address 0x0011 returns the word at 0x0010.
- **Write acks:** with `MEMRESP_WR_ACK_EN` and `LATENCY`=2, issue the interleaved sequence W,R,W → `wr_ack`, `data_valid` and `wr_ack` pulse on consecutive cycles, starting 2 cycles after the first write.

Source files
------------

// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the pipelined memory responder: defaults and the delay-line entry type.
package wisc_mem_pkg;

  localparam int DEF_DWIDTH  = 16;
  localparam int DEF_AWIDTH  = 16;
  localparam int DEF_LATENCY = 4;
  localparam int MAX_LATENCY = 8;
  localparam int OUTST_W     = $clog2(MAX_LATENCY + 1);

  typedef struct packed {
    logic                  valid;
    logic                  is_wr_ack;
    logic [DEF_DWIDTH-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_resp_delay.sv
// LATENCY-stage shift register of response entries; async active-low reset empties every slot.
module mem_resp_delay
  import wisc_mem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic      clk,
  input  logic      rst_n,
  input  mem_resp_t in_entry,
  output mem_resp_t out_entry
);

  mem_resp_t stage_d [LATENCY];
  mem_resp_t stage_q [LATENCY];

  always_comb begin
    stage_d[0] = in_entry;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Clearing the whole entry (not only valid) keeps data_out clean straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_entry = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_resp_pipelined.sv
// Fixed-latency pipelined memory responder: word array, request accept, outstanding counter.
// Optional MEMRESP_WR_ACK_EN adds a wr_ack strobe that travels the read delay line.
module mem_resp_pipelined
  import wisc_mem_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int LATENCY   = DEF_LATENCY,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
`ifdef MEMRESP_WR_ACK_EN
  output logic              wr_ack,
`endif
  output logic [3:0]        outstanding
);

  localparam int WORDS = 1 << (AWIDTH - 1);

  logic [DWIDTH-1:0] mem [WORDS];
  logic [AWIDTH-2:0] word_idx;
  logic [DWIDTH-1:0] rd_word;
  logic              rd_accept;
  logic              wr_accept;
  logic              unused_addr_lsb;
  mem_resp_t         in_entry;
  mem_resp_t         out_entry;
  logic [3:0]        outstanding_d;
  logic [3:0]        outstanding_q;

  assign word_idx        = addr[AWIDTH-1:1];
  assign unused_addr_lsb = addr[0];
  assign rd_accept       = enable && !wr;
  assign wr_accept       = enable && wr;
  assign rd_word         = mem[word_idx];

  // No reset on the array: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[word_idx] <= data_in;
    end
  end

  always_comb begin
    in_entry           = '0;
    in_entry.data      = rd_accept ? DEF_DWIDTH'(rd_word) : '0;
`ifdef MEMRESP_WR_ACK_EN
    in_entry.valid     = enable;
    in_entry.is_wr_ack = wr_accept;
`else
    in_entry.valid     = rd_accept;
    in_entry.is_wr_ack = 1'b0;
`endif
  end

  mem_resp_delay #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst),
    .in_entry  (in_entry),
    .out_entry (out_entry)
  );

  // Increment on entry, decrement as the entry leaves; bounded by LATENCY so it never wraps.
  always_comb begin
    outstanding_d = outstanding_q + 4'(in_entry.valid) - 4'(out_entry.valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  assign outstanding = outstanding_q;
  assign data_valid  = out_entry.valid && !out_entry.is_wr_ack;
  assign data_out    = data_valid ? DWIDTH'(out_entry.data) : '0;

`ifdef MEMRESP_WR_ACK_EN
  assign wr_ack = out_entry.valid && out_entry.is_wr_ack;
`endif

endmodule

// File: tb/tb_mem_resp_pipelined.sv
// Self-checking bench for mem_resp_pipelined: vector table, directed corner sequences, random traffic vs. model.
module tb_mem_resp_pipelined;

`ifdef MEMRESP_WR_ACK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  outstanding;
`ifdef MEMRESP_WR_ACK_EN
  logic        wr_ack;
`endif

  always #5 clk = ~clk;

  mem_resp_pipelined #(
    .DWIDTH  (16),
    .AWIDTH  (16),
    .LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .wr          (wr),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
`ifdef MEMRESP_WR_ACK_EN
    .wr_ack      (wr_ack),
`endif
    .outstanding (outstanding)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: word store plus list of accepted requests with their accept edge.
  typedef struct {
    int          acc;
    bit          is_wr;
    logic [15:0] data;
  } pend_t;

  pend_t       pq[$];
  logic [15:0] mem_m[int];

  logic [15:0] dvq[$];
  int          dvc[$];
  int          peak;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_apply(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    int idx;
    pend_t p;
    idx = int'(a >> 1);
    if (en) begin
      if (w) begin
        mem_m[idx] = d;
`ifdef MEMRESP_WR_ACK_EN
        p.acc = cyc; p.is_wr = 1'b1; p.data = '0;
        pq.push_back(p);
`endif
      end else begin
        p.acc = cyc; p.is_wr = 1'b0;
        p.data = mem_m.exists(idx) ? mem_m[idx] : 16'h0;
        pq.push_back(p);
      end
    end
  endtask

  task automatic check_model();
    logic        e_dv, e_ack;
    logic [15:0] e_do;
    int          e_out;
    e_dv = 0; e_ack = 0; e_do = '0; e_out = 0;
    foreach (pq[i]) begin
      if (pq[i].acc + LAT - 1 == cyc) begin
        if (pq[i].is_wr) e_ack = 1'b1;
        else begin
          e_dv = 1'b1;
          e_do = pq[i].data;
        end
      end
      if (pq[i].acc <= cyc && pq[i].acc + LAT > cyc) e_out++;
    end
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].acc + LAT <= cyc) pq.delete(i);
    end
    chk("model_data_valid", 32'(data_valid), 32'(e_dv));
    chk("model_data_out", 32'(data_out), 32'(e_do));
    chk("model_outstanding", 32'(outstanding), 32'(e_out));
`ifdef MEMRESP_WR_ACK_EN
    chk("model_wr_ack", 32'(wr_ack), 32'(e_ack));
`endif
  endtask

  task automatic cycle(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable = en; wr = w; addr = a; data_in = d;
    @(posedge clk);
    cyc++;
    if (rst) model_apply(en, w, a, d);
    @(negedge clk);
  endtask

  task automatic obs();
    check_model();
    if (data_valid) begin
      dvq.push_back(data_out);
      dvc.push_back(cyc);
    end
    if (int'(outstanding) > peak) peak = int'(outstanding);
  endtask

  task automatic clear_obs();
    dvq.delete();
    dvc.delete();
    peak = 0;
  endtask

  typedef struct {
    logic        en;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        e_dv;
    logic [15:0] e_do;
    logic [3:0]  e_out;
  } vec_t;

  vec_t vt[13];

  initial begin
    int c0;
`ifndef MEMRESP_WR_ACK_EN
    vt[0]  = '{1, 1, 16'h0010, 16'h1234, 0, 16'h0000, 0};
    vt[1]  = '{1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 1};
    vt[2]  = '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1};
    vt[3]  = '{0, 1, 16'h0010, 16'hDEAD, 0, 16'h0000, 1};
    vt[4]  = '{0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 1};
    vt[5]  = '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0};
    vt[6]  = '{1, 0, 16'h0011, 16'h0000, 0, 16'h0000, 1};
    vt[7]  = '{1, 1, 16'h0010, 16'h4321, 0, 16'h0000, 1};
    vt[8]  = '{1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 2};
    vt[9]  = '{0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 2};
    vt[10] = '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1};
    vt[11] = '{0, 0, 16'h0000, 16'h0000, 1, 16'h4321, 1};
    vt[12] = '{0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0};
`endif

    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_data_valid", 32'(data_valid), 0);
      chk("reset_data_out", 32'(data_out), 0);
      chk("reset_outstanding", 32'(outstanding), 0);
    end
    rst = 1'b1;

`ifndef MEMRESP_WR_ACK_EN
    foreach (vt[i]) begin
      cycle(vt[i].en, vt[i].w, vt[i].a, vt[i].d);
      chk($sformatf("vec%0d_data_valid", i), 32'(data_valid), 32'(vt[i].e_dv));
      chk($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vt[i].e_do));
      chk($sformatf("vec%0d_outstanding", i), 32'(outstanding), 32'(vt[i].e_out));
    end
`endif

    // Streaming reads
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 16'(2 * i), 16'hA000 + 16'(i));
      obs();
    end
    clear_obs();
    c0 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 16'(2 * i), 16'h0);
      obs();
    end
    repeat (LAT + 2) begin
      cycle(0, 0, 16'h0, 16'h0);
      obs();
    end
    chk("stream_count", 32'(dvq.size()), 8);
    if (dvq.size() == 8) begin
      chk("stream_first_cycle", 32'(dvc[0] - c0), 32'(LAT - 1));
      chk("stream_last_cycle", 32'(dvc[7] - c0), 32'(LAT + 6));
      for (int i = 0; i < 8; i++) chk($sformatf("stream_data%0d", i), 32'(dvq[i]), 32'(16'hA000 + 16'(i)));
    end
    chk("stream_peak_outstanding", 32'(peak), 32'(LAT));

    // Read-then-write-then-read ordering
    cycle(1, 1, 16'h0040, 16'h5555);
    obs();
    clear_obs();
    cycle(1, 0, 16'h0040, 16'h0);
    obs();
    cycle(1, 1, 16'h0040, 16'hBEEF);
    obs();
    cycle(1, 0, 16'h0040, 16'h0);
    obs();
    repeat (LAT + 1) begin
      cycle(0, 0, 16'h0, 16'h0);
      obs();
    end
    chk("order_count", 32'(dvq.size()), 2);
    if (dvq.size() == 2) begin
      chk("order_old", 32'(dvq[0]), 32'h5555);
      chk("order_new", 32'(dvq[1]), 32'hBEEF);
    end

    // Reset with reads in flight
    cycle(1, 1, 16'h0020, 16'h77AA);
    obs();
    cycle(1, 1, 16'h0010, 16'h1234);
    obs();
    cycle(1, 0, 16'h0020, 16'h0);
    obs();
    cycle(1, 0, 16'h0020, 16'h0);
    obs();
    enable = 1'b0;
    rst = 1'b0;
    #1;
    pq.delete();
    chk("midrst_data_valid", 32'(data_valid), 0);
    chk("midrst_outstanding", 32'(outstanding), 0);
    chk("midrst_data_out", 32'(data_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_obs();
    repeat (LAT + 2) begin
      cycle(0, 0, 16'h0, 16'h0);
      obs();
      chk("postrst_no_valid", 32'(data_valid), 0);
    end
    chk("postrst_none_returned", 32'(dvq.size()), 0);
    cycle(1, 0, 16'h0020, 16'h0);
    obs();
    cycle(1, 0, 16'h0011, 16'h0);
    obs();
    repeat (LAT + 1) begin
      cycle(0, 0, 16'h0, 16'h0);
      obs();
    end
    chk("postrst_count", 32'(dvq.size()), 2);
    if (dvq.size() == 2) begin
      chk("postrst_persist", 32'(dvq[0]), 32'h77AA);
      chk("odd_addr", 32'(dvq[1]), 32'h1234);
    end

`ifdef MEMRESP_WR_ACK_EN
    begin
      logic e_ack[6];
      logic e_dv[6];
      e_ack = '{0, 1, 0, 1, 0, 0};
      e_dv  = '{0, 0, 1, 0, 0, 0};
      for (int k = 0; k < 6; k++) begin
        if (k == 0) cycle(1, 1, 16'h0030, 16'h1111);
        else if (k == 1) cycle(1, 0, 16'h0030, 16'h0);
        else if (k == 2) cycle(1, 1, 16'h0030, 16'h2222);
        else cycle(0, 0, 16'h0, 16'h0);
        chk($sformatf("ack_seq%0d_wr_ack", k), 32'(wr_ack), 32'(e_ack[k]));
        chk($sformatf("ack_seq%0d_data_valid", k), 32'(data_valid), 32'(e_dv[k]));
        check_model();
      end
    end
`endif

    // Random traffic over a pre-written window
    for (int i = 0; i < 32; i++) begin
      cycle(1, 1, 16'(2 * i), 16'($urandom));
      obs();
    end
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom));
      obs();
    end
    repeat (LAT + 1) begin
      cycle(0, 0, 16'h0, 16'h0);
      obs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
